// File: rtl/stopwatch_core.sv
// Stopwatch/timer datapath: hundredths, seconds, minutes, hours with up/down count, preset load and terminal pulses.
// Optional lap-freeze snapshot is built when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic       dir,
  input  logic       load,
  input  logic [4:0] i_pre_hour,
  input  logic [5:0] i_pre_min,
  input  logic [5:0] i_pre_sec,
  input  logic       lap,
  output logic [6:0] o_csec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_lap_valid,
  output logic       o_done,
  output logic       o_rollover
);

  localparam int DIV = CLK_FREQ / 100;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [4:0]    HOUR_LAST  = 5'(HOUR_MAX - 1);

  logic [PW-1:0] presc;
  logic          tick_r;
  logic [6:0]    csec_r;
  logic [5:0]    sec_r, min_r;
  logic [4:0]    hour_r;
  logic          done_r, roll_r;

  logic [6:0] csec_n;
  logic [5:0] sec_n, min_n;
  logic [4:0] hour_n;
  logic       done_n, roll_n;
  logic       all_zero, all_max;

  logic [4:0] pre_hour_c;
  logic [5:0] pre_min_c, pre_sec_c;

  // Whole carry/borrow chain resolves in one cycle so every field moves on the same edge.
  always_comb begin
    csec_n   = csec_r;
    sec_n    = sec_r;
    min_n    = min_r;
    hour_n   = hour_r;
    done_n   = 1'b0;
    roll_n   = 1'b0;
    all_zero = (csec_r == 7'd0) && (sec_r == 6'd0) && (min_r == 6'd0) && (hour_r == 5'd0);
    all_max  = (csec_r == 7'd99) && (sec_r == 6'd59) && (min_r == 6'd59) && (hour_r == HOUR_LAST);
    if (!dir) begin
      roll_n = all_max;
      if (csec_r != 7'd99) begin
        csec_n = csec_r + 7'd1;
      end else begin
        csec_n = 7'd0;
        if (sec_r != 6'd59) begin
          sec_n = sec_r + 6'd1;
        end else begin
          sec_n = 6'd0;
          if (min_r != 6'd59) begin
            min_n = min_r + 6'd1;
          end else begin
            min_n  = 6'd0;
            hour_n = (hour_r == HOUR_LAST) ? 5'd0 : hour_r + 5'd1;
          end
        end
      end
    end else if (!all_zero) begin
      done_n = (csec_r == 7'd1) && (sec_r == 6'd0) && (min_r == 6'd0) && (hour_r == 5'd0);
      if (csec_r != 7'd0) begin
        csec_n = csec_r - 7'd1;
      end else begin
        csec_n = 7'd99;
        if (sec_r != 6'd0) begin
          sec_n = sec_r - 6'd1;
        end else begin
          sec_n = 6'd59;
          if (min_r != 6'd0) begin
            min_n = min_r - 6'd1;
          end else begin
            min_n  = 6'd59;
            hour_n = hour_r - 5'd1;
          end
        end
      end
    end
  end

  always_comb begin
    pre_hour_c = (i_pre_hour > HOUR_LAST) ? HOUR_LAST : i_pre_hour;
    pre_min_c  = (i_pre_min > 6'd59) ? 6'd59 : i_pre_min;
    pre_sec_c  = (i_pre_sec > 6'd59) ? 6'd59 : i_pre_sec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      tick_r <= 1'b0;
      csec_r <= '0;
      sec_r  <= '0;
      min_r  <= '0;
      hour_r <= '0;
      done_r <= 1'b0;
      roll_r <= 1'b0;
    end else if (clear) begin
      presc  <= '0;
      tick_r <= 1'b0;
      csec_r <= '0;
      sec_r  <= '0;
      min_r  <= '0;
      hour_r <= '0;
      done_r <= 1'b0;
      roll_r <= 1'b0;
    end else if (load) begin
      presc  <= '0;
      tick_r <= 1'b0;
      csec_r <= '0;
      sec_r  <= pre_sec_c;
      min_r  <= pre_min_c;
      hour_r <= pre_hour_c;
      done_r <= 1'b0;
      roll_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      roll_r <= 1'b0;
      // A tick already raised is consumed even if run has just dropped.
      if (tick_r) begin
        csec_r <= csec_n;
        sec_r  <= sec_n;
        min_r  <= min_n;
        hour_r <= hour_n;
        done_r <= done_n;
        roll_r <= roll_n;
      end
      if (run) begin
        if (presc == PRESC_LAST) begin
          presc  <= '0;
          tick_r <= 1'b1;
        end else begin
          presc  <= presc + 1'b1;
          tick_r <= 1'b0;
        end
      end else begin
        tick_r <= 1'b0;
      end
    end
  end

  assign o_done     = done_r;
  assign o_rollover = roll_r;

`ifdef STOPWATCH_LAP_EN
  logic       lap_valid_r;
  logic [6:0] lap_csec;
  logic [5:0] lap_sec, lap_min;
  logic [4:0] lap_hour;

  // Load does not touch the freeze; clear releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_valid_r <= 1'b0;
      lap_csec    <= '0;
      lap_sec     <= '0;
      lap_min     <= '0;
      lap_hour    <= '0;
    end else if (clear) begin
      lap_valid_r <= 1'b0;
    end else if (lap) begin
      if (!lap_valid_r) begin
        lap_valid_r <= 1'b1;
        lap_csec    <= csec_r;
        lap_sec     <= sec_r;
        lap_min     <= min_r;
        lap_hour    <= hour_r;
      end else begin
        lap_valid_r <= 1'b0;
      end
    end
  end

  assign o_lap_valid = lap_valid_r;
  assign o_csec      = lap_valid_r ? lap_csec : csec_r;
  assign o_sec       = lap_valid_r ? lap_sec  : sec_r;
  assign o_min       = lap_valid_r ? lap_min  : min_r;
  assign o_hour      = lap_valid_r ? lap_hour : hour_r;
`else
  logic unused_lap;
  assign unused_lap  = lap;
  assign o_lap_valid = 1'b0;
  assign o_csec      = csec_r;
  assign o_sec       = sec_r;
  assign o_min       = min_r;
  assign o_hour      = hour_r;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: vector table, hand-written corner sequences and a randomized run
// against a reference model that keeps time as a single count of hundredths.
module tb_stopwatch_core;

  localparam int CLK_FREQ = 1000;
  localparam int HOUR_MAX = 24;
  localparam int DIV      = CLK_FREQ / 100;
  localparam int DAY      = HOUR_MAX * 360000;

  logic       clk, rst, run, clear, dir, load, lap;
  logic [4:0] i_pre_hour;
  logic [5:0] i_pre_min, i_pre_sec;
  logic [6:0] o_csec;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic       o_lap_valid, o_done, o_rollover;

  stopwatch_core #(.CLK_FREQ(CLK_FREQ), .HOUR_MAX(HOUR_MAX)) dut (
    .clk(clk), .rst(rst), .run(run), .clear(clear), .dir(dir), .load(load),
    .i_pre_hour(i_pre_hour), .i_pre_min(i_pre_min), .i_pre_sec(i_pre_sec), .lap(lap),
    .o_csec(o_csec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_lap_valid(o_lap_valid), .o_done(o_done), .o_rollover(o_rollover)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int roll_cnt = 0;
  int done_cnt = 0;

  // reference model state
  bit model_on = 1'b0;
  int m_phase, m_total, m_lap_total;
  bit m_tick, m_done, m_roll, m_lapv;

  typedef struct {
    string name;
    int    ph, pm, ps;
    bit    d;
    int    ticks;
    int    eh, em, es, ec;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  task automatic model_edge();
    if (clear) begin
      m_phase = 0; m_tick = 0; m_total = 0; m_done = 0; m_roll = 0; m_lapv = 0;
    end else begin
`ifdef STOPWATCH_LAP_EN
      if (lap) begin
        if (!m_lapv) begin
          m_lap_total = m_total;
          m_lapv = 1;
        end else begin
          m_lapv = 0;
        end
      end
`endif
      if (load) begin
        m_total = ((clampi(int'(i_pre_hour), HOUR_MAX - 1) * 60 + clampi(int'(i_pre_min), 59)) * 60
                   + clampi(int'(i_pre_sec), 59)) * 100;
        m_phase = 0; m_tick = 0; m_done = 0; m_roll = 0;
      end else begin
        m_done = 0;
        m_roll = 0;
        if (m_tick) begin
          if (!dir) begin
            m_total = (m_total + 1) % DAY;
            m_roll  = (m_total == 0);
          end else if (m_total > 0) begin
            m_total = m_total - 1;
            m_done  = (m_total == 0);
          end
        end
        if (run) begin
          m_phase = (m_phase + 1) % DIV;
          m_tick  = (m_phase == 0);
        end else begin
          m_tick = 0;
        end
      end
    end
  endtask

  function automatic logic [26:0] model_vec();
    int t;
    t = m_lapv ? m_lap_total : m_total;
    return {7'(t % 100), 6'((t / 100) % 60), 6'((t / 6000) % 60), 5'(t / 360000), m_lapv, m_done, m_roll};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {o_csec, o_sec, o_min, o_hour, o_lap_valid, o_done, o_rollover};
  endfunction

  // One active edge; outputs are sampled at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    if (model_on) model_edge();
    @(negedge clk);
    if (o_rollover) roll_cnt++;
    if (o_done) done_cnt++;
  endtask

  task automatic do_clear(input bit r);
    clear = 1'b1; run = r;
    cyc();
    clear = 1'b0;
  endtask

  task automatic do_load(input int h, input int m, input int s, input bit d, input bit r);
    i_pre_hour = 5'(h); i_pre_min = 6'(m); i_pre_sec = 6'(s);
    dir = d; run = r; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s, input int c);
    check({name, ".hour"}, 32'(o_hour), h);
    check({name, ".min"},  32'(o_min),  m);
    check({name, ".sec"},  32'(o_sec),  s);
    check({name, ".csec"}, 32'(o_csec), c);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; clear = 1'b0; dir = 1'b0; load = 1'b0; lap = 1'b0;
    i_pre_hour = '0; i_pre_min = '0; i_pre_sec = '0;

    vecs[0] = '{"clamp",      30, 63, 60, 1'b0, 0,   23, 59, 59, 0};
    vecs[1] = '{"up5",         1,  2,  3, 1'b0, 5,    1,  2,  3, 5};
    vecs[2] = '{"up_carry",    0, 59, 59, 1'b0, 100,  1,  0,  0, 0};
    vecs[3] = '{"dn_borrow",   2,  0,  0, 1'b1, 1,    1, 59, 59, 99};
    vecs[4] = '{"dn_hold",     0,  0,  0, 1'b1, 3,    0,  0,  0, 0};
    vecs[5] = '{"up_wrap",    23, 59, 59, 1'b0, 100,  0,  0,  0, 0};
    vecs[6] = '{"dn_150",      0,  1,  0, 1'b1, 150,  0,  0, 58, 50};

    // reset
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(dut_vec()), 0);
    rst = 1'b0;
    cyc();
    check("post_reset_outputs", 32'(dut_vec()), 0);

    // first tick latency and one second of counting up
    do_clear(1'b1);
    roll_cnt = 0; done_cnt = 0;
    repeat (DIV) cyc();
    check("csec_before_edge11", 32'(o_csec), 0);
    cyc();
    check("csec_at_edge11", 32'(o_csec), 1);
    repeat (990) cyc();
    check_time("one_second", 0, 0, 1, 0);
    check("no_pulses_count_up", 32'(roll_cnt + done_cnt), 0);

    // pending tick survives run dropping
    do_clear(1'b1);
    repeat (DIV) cyc();
    run = 1'b0;
    cyc();
    check("tick_after_run_drop", 32'(o_csec), 1);

    // vector table
    foreach (vecs[i]) begin
      do_clear(1'b0);
      do_load(vecs[i].ph, vecs[i].pm, vecs[i].ps, vecs[i].d, vecs[i].ticks > 0);
      if (vecs[i].ticks > 0) repeat (vecs[i].ticks * DIV + 1) cyc();
      run = 1'b0;
      check_time(vecs[i].name, vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ec);
    end

    // rollover pulse
    do_clear(1'b0);
    do_load(23, 59, 59, 1'b0, 1'b1);
    roll_cnt = 0;
    repeat (100 * DIV) cyc();
    check("roll_not_early", 32'(roll_cnt), 0);
    cyc();
    check_time("rollover", 0, 0, 0, 0);
    check("rollover_pulse", 32'(o_rollover), 1);
    repeat (20) cyc();
    check("rollover_once", 32'(roll_cnt), 1);

    // countdown done pulse and hold at zero
    do_clear(1'b0);
    do_load(0, 0, 1, 1'b1, 1'b1);
    done_cnt = 0;
    repeat (100 * DIV + 1) cyc();
    check_time("countdown_zero", 0, 0, 0, 0);
    check("done_pulse", 32'(o_done), 1);
    repeat (20 * DIV) cyc();
    check_time("countdown_hold", 0, 0, 0, 0);
    check("done_once", 32'(done_cnt), 1);
    dir = 1'b0;

    // pause keeps prescaler phase
    do_clear(1'b1);
    repeat (57 * DIV + 1) cyc();
    check("pause_start", 32'(o_csec), 57);
    run = 1'b0;
    repeat (35) cyc();
    check("pause_hold", 32'(o_csec), 57);
    run = 1'b1;
    repeat (DIV - 1) cyc();
    check("resume_no_early_tick", 32'(o_csec), 57);
    cyc();
    check("resume_tick", 32'(o_csec), 58);
    repeat (DIV) cyc();
    check("resume_next_tick", 32'(o_csec), 59);

    // lap freeze
    do_clear(1'b1);
    repeat (42 * DIV + 1) cyc();
    lap = 1'b1;
    cyc();
    lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
    check("lap_valid_set", 32'(o_lap_valid), 1);
    check("lap_frozen", 32'(o_csec), 42);
    repeat (100) cyc();
    check("lap_still_frozen", 32'(o_csec), 42);
    lap = 1'b1;
    cyc();
    lap = 1'b0;
    check("lap_valid_clr", 32'(o_lap_valid), 0);
    check("lap_live", 32'(o_csec), 52);
    lap = 1'b1;
    cyc();
    lap = 1'b0;
    repeat (5) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_in_freeze_valid", 32'(o_lap_valid), 0);
    check("clear_in_freeze_outputs", 32'(dut_vec()), 0);
`else
    check("lap_ignored_valid", 32'(o_lap_valid), 0);
    repeat (100) cyc();
    check("lap_ignored_live", 32'(o_csec), 52);
`endif

    // randomized run against the hundredths-count model
    model_on = 1'b1;
    do_clear(1'b1);
    check("rand_start", 32'(dut_vec()), 32'(model_vec()));
    for (int n = 0; n < 6000; n++) begin
      run   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) dir = ~dir;
      clear = ($urandom_range(0, 999) == 0);
      lap   = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 3))
        0: begin i_pre_hour = 5'd23; i_pre_min = 6'd59; i_pre_sec = 6'd59; end
        1: begin i_pre_hour = 5'd0;  i_pre_min = 6'd0;  i_pre_sec = 6'(1 + $urandom_range(0, 2)); end
        default: begin
          i_pre_hour = 5'($urandom_range(0, 31));
          i_pre_min  = 6'($urandom_range(0, 63));
          i_pre_sec  = 6'($urandom_range(0, 63));
        end
      endcase
      cyc();
      check("rand_outputs", 32'(dut_vec()), 32'(model_vec()));
    end
    clear = 1'b0; load = 1'b0; lap = 1'b0; run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
